// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioner: channel indices and
// per-channel debounce FSM state encoding.
package btn_pkg;

  localparam int unsigned NUM_BTN   = 3;

  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_PAUSE = 1;
  localparam int unsigned BTN_RESET = 2;

  localparam logic [0:0] RELEASED = 1'b0;
  localparam logic [0:0] HELD     = 1'b1;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, RELEASED/HELD FSM
// and a registered active-low single-cycle command pulse (optionally hold-delayed).
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter bit          HOLD            = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic cmd,
  output logic pressed
);

  localparam int unsigned     CW          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned     HOLD_TARGET = HOLD ? HOLD_CYCLES : 0;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [0:0]    state;
  logic          disagree;
  logic          flip;
  logic          fire;

  // raw is active-low: RELEASED expects sync2=1, HELD expects sync2=0
  assign disagree = (sync2 == state[0]);
  // the counter reaching DEBOUNCE_CYCLES on this edge commits the new level
  assign flip     = disagree && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      cnt     <= '0;
      state   <= RELEASED;
      pressed <= 1'b0;
      cmd     <= 1'b1;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      if (!disagree || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (flip) begin
        state <= ~state;
      end
      pressed <= state[0];
      cmd     <= ~fire;
    end
  end

  if (HOLD_TARGET == 0) begin : g_direct
    // first cycle in HELD as seen through the registered level
    assign fire = (state == HELD) && !pressed;
  end else begin : g_hold
    localparam int unsigned   HW        = $clog2(HOLD_TARGET + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TARGET - 1);
    localparam logic [HW-1:0] HOLD_DONE = HW'(HOLD_TARGET);

    logic [HW-1:0] hcnt;

    // once the pulse has fired, hcnt parks at HOLD_DONE until release so a
    // later bounce cannot re-arm it; before that, any disagreement restarts it
    always_ff @(posedge clk) begin
      if (rst || !pressed) begin
        hcnt <= '0;
      end else if (hcnt == HOLD_DONE) begin
        hcnt <= hcnt;
      end else if (disagree) begin
        hcnt <= '0;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end

    assign fire = (state == HELD) && pressed && !disagree && (hcnt == HOLD_LAST);
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions three active-low bouncing buttons into active-low one-shot commands.
// Define BTN_RESET_HOLD_EN to require a long hold on the reset button.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] raw_btn,
  output logic [NUM_BTN-1:0] botones,
  output logic [NUM_BTN-1:0] pressed
);

`ifdef BTN_RESET_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .HOLD            (HOLD_ON && (i == BTN_RESET))
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .raw     (raw_btn[i]),
      .cmd     (botones[i]),
      .pressed (pressed[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
module tb_btn_conditioner;

`ifdef BTN_RESET_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw_btn;
  logic [2:0] botones;
  logic [2:0] pressed;

  int checks = 0;
  int errors = 0;
  int pcnt [3] = '{0, 0, 0};
  int base [3];

  btn_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .raw_btn (raw_btn),
    .botones (botones),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (botones[i] === 1'b0) pcnt[i] <= pcnt[i] + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 3; i++) base[i] = pcnt[i];
  endtask

  initial begin
    // 1: reset with all buttons held, then one pulse each after release of rst
    rst = 1'b1;
    raw_btn = 3'b000;
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("rst_botones", botones, 3'b111);
      chk("rst_pressed", pressed, 3'b000);
    end
    rst = 1'b0;
    snap();
    step(6);
    chk("post_rst_wait", botones, 3'b111);
    step(1);
    chk("post_rst_pulse", botones, HOLD_ON ? 3'b100 : 3'b000);
    chk("post_rst_pressed", pressed, 3'b111);
    step(1);
    chk("post_rst_after", botones, 3'b111);
    if (HOLD_ON) begin
      step(6);
      chk("post_rst_hold_wait", botones, 3'b111);
      step(1);
      chk("post_rst_hold_pulse", botones, 3'b011);
      step(1);
    end
    raw_btn = 3'b111;
    step(6);
    chk("t1_release_wait", pressed, 3'b111);
    step(1);
    chk("t1_release", pressed, 3'b000);
    step(3);
    for (int i = 0; i < 3; i++) chkn("t1_pulses", pcnt[i] - base[i], 1);

    // 2: clean press on start
    snap();
    raw_btn = 3'b110;
    step(6);
    chk("t2_wait_b", botones, 3'b111);
    chk("t2_wait_p", pressed, 3'b000);
    step(1);
    chk("t2_pulse_b", botones, 3'b110);
    chk("t2_pulse_p", pressed, 3'b001);
    step(1);
    chk("t2_after_b", botones, 3'b111);
    step(42);
    chk("t2_held_p", pressed, 3'b001);
    chk("t2_held_b", botones, 3'b111);
    raw_btn = 3'b111;
    step(6);
    chk("t2_rel_wait", pressed, 3'b001);
    step(1);
    chk("t2_rel", pressed, 3'b000);
    step(3);
    chkn("t2_pulses", pcnt[0] - base[0], 1);

    // 3: bouncing press on pause
    snap();
    raw_btn = 3'b101; step(3);
    raw_btn = 3'b111; step(1);
    raw_btn = 3'b101; step(2);
    raw_btn = 3'b111; step(1);
    raw_btn = 3'b101;
    step(6);
    chk("t3_wait_b", botones, 3'b111);
    chkn("t3_no_glitch_pulse", pcnt[1] - base[1], 0);
    step(1);
    chk("t3_pulse", botones, 3'b101);
    step(10);
    chkn("t3_pulses", pcnt[1] - base[1], 1);
    raw_btn = 3'b111;
    step(10);
    chk("t3_rel", pressed, 3'b000);

    // 4: simultaneous start and pause
    raw_btn = 3'b100;
    step(6);
    chk("t4_wait", botones, 3'b111);
    step(1);
    chk("t4_pulse", botones, 3'b100);
    step(1);
    chk("t4_after_b", botones, 3'b111);
    chk("t4_after_p", pressed, 3'b011);
    raw_btn = 3'b111;
    step(10);
    chk("t4_rel", pressed, 3'b000);

    // 5: reset button, short then long hold
    snap();
    raw_btn = 3'b011;
    step(6);
    chk("t5s_wait", botones, 3'b111);
    step(1);
    chk("t5s_at7", botones, HOLD_ON ? 3'b111 : 3'b011);
    step(5);
    raw_btn = 3'b111;
    step(10);
    chk("t5s_rel", pressed, 3'b000);
    chkn("t5s_pulses", pcnt[2] - base[2], HOLD_ON ? 0 : 1);
    snap();
    raw_btn = 3'b011;
    step(14);
    chk("t5l_wait", botones, 3'b111);
    step(1);
    chk("t5l_at15", botones, HOLD_ON ? 3'b011 : 3'b111);
    step(5);
    raw_btn = 3'b111;
    step(10);
    chk("t5l_rel", pressed, 3'b000);
    chkn("t5l_pulses", pcnt[2] - base[2], 1);

    // 6: reset while pause is held
    raw_btn = 3'b101;
    step(8);
    chk("t6_held", pressed, 3'b010);
    rst = 1'b1;
    step(1);
    chk("t6_rst_p", pressed, 3'b000);
    chk("t6_rst_b", botones, 3'b111);
    rst = 1'b0;
    snap();
    step(6);
    chk("t6_wait_b", botones, 3'b111);
    chk("t6_wait_p", pressed, 3'b000);
    step(1);
    chk("t6_pulse_b", botones, 3'b101);
    chk("t6_pulse_p", pressed, 3'b010);
    step(5);
    chkn("t6_pulses", pcnt[1] - base[1], 1);
    raw_btn = 3'b111;
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
